// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, parity modes and
// bit-period arithmetic used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  typedef logic [7:0] uart_byte_t;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_ODD  = 1;
  localparam int unsigned PAR_EVEN = 2;

  // Clock cycles per line bit, truncated; evaluated in 64 bits so fast clocks cannot overflow.
  function automatic int unsigned calc_bit_cycles(input int unsigned clk_mhz,
                                                  input int unsigned baud);
    return 32'((64'(clk_mhz) * 64'd1_000_000) / 64'(baud));
  endfunction

endpackage

// File: rtl/uart_byte_tx_if.sv
// Byte handshake between an upstream producer (master) and the transmitter (slave).
interface uart_byte_tx_if;
  import uart_pkg::*;

  uart_byte_t tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;

  modport master (output tx_data, output tx_data_valid, input tx_data_ready);
  modport slave  (input tx_data, input tx_data_valid, output tx_data_ready);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BIT_CYCLES-1 while enabled and flags the last
// cycle of each period; held at zero while disabled.
module uart_baud_cnt #(
  parameter int unsigned BIT_CYCLES = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic wrap_c
);

  localparam int unsigned CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    wrap_c = en && (cnt_q == CNT_MAX);
    cnt_d  = '0;
    if (en && !wrap_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_byte_tx.sv
// Single-byte UART transmitter: start bit, 8 data bits LSB first, optional
// parity, 1 or 2 stop bits. The line output lags the state register by one cycle.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 200,
  parameter int unsigned BAUD_RATE = 115200,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic           sys_clk,
  input  logic           rst_n,
  uart_byte_tx_if.slave  tx_if,
  output logic           tx_busy,
  output logic           tx_pin
);

  localparam int unsigned BIT_CYCLES = calc_bit_cycles(CLK_FRE, BAUD_RATE);

  if (BIT_CYCLES < 2) begin : g_bad_bit_cycles
    $error("uart_byte_tx: BIT_CYCLES must be at least 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_byte_tx: STOP_BITS must be 1 or 2");
  end
  if (PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_byte_tx: PARITY must be 0, 1 or 2");
  end

  tx_state_e  state_q,   state_d;
  uart_byte_t data_q,    data_d;
  logic       parity_q,  parity_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic       tx_pin_q,  tx_pin_d;
  logic       busy_q,    busy_d;
  logic       ready_q,   ready_d;

  logic       accept_c;
  logic       bit_wrap_c;
  logic       cnt_en_c;

  assign cnt_en_c = (state_q != S_IDLE);

  uart_baud_cnt #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_baud_cnt (
    .clk    (sys_clk),
    .rst_n  (rst_n),
    .en     (cnt_en_c),
    .wrap_c (bit_wrap_c)
  );

  // Next state, handshake and line value; bit_idx also counts stop bits.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    parity_d  = parity_q;
    bit_idx_d = bit_idx_q;
    busy_d    = busy_q;
    ready_d   = ready_q;
    tx_pin_d  = 1'b1;
    accept_c  = tx_if.tx_data_valid && ready_q;

    unique case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (accept_c) begin
          data_d    = tx_if.tx_data;
          parity_d  = (PARITY == PAR_ODD) ? ~^tx_if.tx_data : ^tx_if.tx_data;
          bit_idx_d = '0;
          state_d   = S_START;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_START: begin
        if (bit_wrap_c) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_wrap_c) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (bit_wrap_c) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_wrap_c) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            state_d   = S_IDLE;
            bit_idx_d = '0;
            busy_d    = 1'b0;
            ready_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    unique case (state_q)
      S_START:  tx_pin_d = 1'b0;
      S_DATA:   tx_pin_d = data_q[bit_idx_q];
      S_PARITY: tx_pin_d = parity_q;
      default:  tx_pin_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      parity_q  <= 1'b0;
      bit_idx_q <= '0;
      tx_pin_q  <= 1'b1;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      parity_q  <= parity_d;
      bit_idx_q <= bit_idx_d;
      tx_pin_q  <= tx_pin_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
    end
  end

  assign tx_if.tx_data_ready = ready_q;
  assign tx_busy             = busy_q;
  assign tx_pin              = tx_pin_q;

endmodule
